// File: rtl/mig_app_pkg.sv
// Shared definitions for the MIG app-interface responder: command encodings,
// default widths and the address-to-line mapping.
package mig_app_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    localparam int DEFAULT_ADDR_W = 28;
    localparam int DEFAULT_DATA_W = 256;

    // Addresses are widened to this before line extraction so one function serves any ADDR_W.
    localparam int ADDR_FN_W   = 64;
    localparam int LINE_OFFSET = 3;

    // Drops the burst-offset bits; the caller keeps as many low bits as the array needs.
    function automatic logic [ADDR_FN_W-1:0] line_of_addr(input logic [ADDR_FN_W-1:0] addr);
        return addr >> LINE_OFFSET;
    endfunction

endpackage

// File: rtl/app_sync_fifo2.sv
// Two-entry synchronous FIFO with full/empty flags; used for queued write
// commands and queued write data.
module app_sync_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(do_push) - 2'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mig_app_bram_responder.sv
// Block-RAM stand-in for the 7-series MIG app interface: calibration delay,
// command/write-data handshakes, fixed-latency reads and ref/zq acknowledges.
module mig_app_bram_responder
    import mig_app_pkg::*;
#(
    parameter int ADDR_W        = DEFAULT_ADDR_W,
    parameter int DATA_W        = DEFAULT_DATA_W,
    parameter int DEPTH_LOG2    = 6,
    parameter int CALIB_CYCLES  = 64,
    parameter int RD_LATENCY    = 4,
    parameter int MAINT_LATENCY = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   app_addr,
    input  logic [2:0]          app_cmd,
    input  logic                app_en,
    output logic                app_rdy,
    input  logic [DATA_W-1:0]   app_wdf_data,
    input  logic [DATA_W/8-1:0] app_wdf_mask,
    input  logic                app_wdf_wren,
    input  logic                app_wdf_end,
    output logic                app_wdf_rdy,
    output logic [DATA_W-1:0]   app_rd_data,
    output logic                app_rd_data_valid,
    output logic                app_rd_data_end,
    input  logic                app_ref_req,
    input  logic                app_zq_req,
    input  logic                app_sr_req,
    output logic                app_ref_ack,
    output logic                app_zq_ack,
    output logic                app_sr_active,
    output logic                init_calib_complete
);

    localparam int MASK_W = DATA_W / 8;
    localparam int WD_W   = DATA_W + MASK_W;
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int CAL_W  = $clog2(CALIB_CYCLES + 1);
    localparam int MNT_W  = $clog2(MAINT_LATENCY + 1);

    logic [ADDR_FN_W-1:0]  line_full;
    logic [DEPTH_LOG2-1:0] cmd_idx;
    logic                  calib_q, calib_d;
    logic [CAL_W-1:0]      cal_cnt_q, cal_cnt_d;
    logic                  wcq_full, wcq_empty, wcq_push, wcq_pop;
    logic [DEPTH_LOG2-1:0] wcq_head;
    logic                  wdq_full, wdq_empty, wdq_push, wdq_pop;
    logic [WD_W-1:0]       wdq_head;
    logic                  cmd_acc, wr_cmd, rd_cmd, wdata_acc, commit;
    logic [DEPTH_LOG2-1:0] commit_idx;
    logic [WD_W-1:0]       commit_wd;
    logic [MASK_W-1:0]     commit_mask;
    logic [DATA_W-1:0]     commit_data;
    logic [DATA_W-1:0]     mem [DEPTH];
    logic [RD_LATENCY-1:0] rd_vld_q, rd_vld_d;
    logic [DEPTH_LOG2-1:0] rd_idx_q, rd_idx_d;
    logic [DATA_W-1:0]     rd_pipe [1:RD_LATENCY-1];
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d;
    logic                  ref_req_q, ref_req_d, zq_req_q, zq_req_d;
    logic [MNT_W-1:0]      ref_cnt_q, ref_cnt_d, zq_cnt_q, zq_cnt_d;
    logic                  ref_ack_q, ref_ack_d, zq_ack_q, zq_ack_d;
    logic                  unused_ok;

    assign line_full = line_of_addr(ADDR_FN_W'(app_addr));
    assign cmd_idx   = line_full[DEPTH_LOG2-1:0];
    assign unused_ok = ^{line_full, app_wdf_end, app_sr_req, wcq_full};

    // A pending write command blocks all commands, so reads never overtake writes.
    assign app_rdy     = calib_q && wcq_empty;
    assign app_wdf_rdy = calib_q && !wdq_full;
    assign cmd_acc     = app_en && app_rdy;
    assign wr_cmd      = cmd_acc && (app_cmd == CMD_WRITE);
    assign rd_cmd      = cmd_acc && (app_cmd == CMD_READ);
    assign wdata_acc   = app_wdf_wren && app_wdf_rdy;

    // Heads may come straight from this cycle's inputs; such entries bypass the queue.
    assign commit      = (!wcq_empty || wr_cmd) && (!wdq_empty || wdata_acc);
    assign commit_idx  = wcq_empty ? cmd_idx : wcq_head;
    assign commit_wd   = wdq_empty ? {app_wdf_mask, app_wdf_data} : wdq_head;
    assign commit_mask = commit_wd[WD_W-1:DATA_W];
    assign commit_data = commit_wd[DATA_W-1:0];
    assign wcq_push    = wr_cmd && !(commit && wcq_empty);
    assign wcq_pop     = commit && !wcq_empty;
    assign wdq_push    = wdata_acc && !(commit && wdq_empty);
    assign wdq_pop     = commit && !wdq_empty;

    app_sync_fifo2 #(.WIDTH(DEPTH_LOG2)) u_wcq (
        .clk       (clk),
        .rst       (rst),
        .push      (wcq_push),
        .push_data (cmd_idx),
        .pop       (wcq_pop),
        .head      (wcq_head),
        .full      (wcq_full),
        .empty     (wcq_empty)
    );

    app_sync_fifo2 #(.WIDTH(WD_W)) u_wdq (
        .clk       (clk),
        .rst       (rst),
        .push      (wdq_push),
        .push_data ({app_wdf_mask, app_wdf_data}),
        .pop       (wdq_pop),
        .head      (wdq_head),
        .full      (wdq_full),
        .empty     (wdq_empty)
    );

    // Array and read data path carry no reset so contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (!commit_mask[b]) begin
                    mem[commit_idx][b*8 +: 8] <= commit_data[b*8 +: 8];
                end
            end
        end
        rd_pipe[1] <= mem[rd_idx_q];
        for (int s = 2; s < RD_LATENCY; s++) begin
            rd_pipe[s] <= rd_pipe[s-1];
        end
    end

    always_comb begin
        calib_d   = calib_q;
        cal_cnt_d = cal_cnt_q;
        if (!calib_q) begin
            if (cal_cnt_q == CAL_W'(CALIB_CYCLES - 1)) begin
                calib_d = 1'b1;
            end else begin
                cal_cnt_d = cal_cnt_q + CAL_W'(1);
            end
        end

        rd_vld_d   = {rd_vld_q[RD_LATENCY-2:0], rd_cmd};
        rd_idx_d   = rd_cmd ? cmd_idx : rd_idx_q;
        rd_valid_d = rd_vld_q[RD_LATENCY-1];
        rd_data_d  = rd_vld_q[RD_LATENCY-1] ? rd_pipe[RD_LATENCY-1] : rd_data_q;

        // Down-counters double as busy flags; new requests only load an idle counter.
        ref_req_d = app_ref_req;
        ref_cnt_d = ref_cnt_q;
        if (ref_cnt_q != '0) begin
            ref_cnt_d = ref_cnt_q - MNT_W'(1);
        end else if (app_ref_req && !ref_req_q) begin
            ref_cnt_d = MNT_W'(MAINT_LATENCY);
        end
        ref_ack_d = (ref_cnt_q == MNT_W'(1));

        zq_req_d = app_zq_req;
        zq_cnt_d = zq_cnt_q;
        if (zq_cnt_q != '0) begin
            zq_cnt_d = zq_cnt_q - MNT_W'(1);
        end else if (app_zq_req && !zq_req_q) begin
            zq_cnt_d = MNT_W'(MAINT_LATENCY);
        end
        zq_ack_d = (zq_cnt_q == MNT_W'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            calib_q    <= 1'b0;
            cal_cnt_q  <= '0;
            rd_vld_q   <= '0;
            rd_idx_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            ref_req_q  <= 1'b0;
            ref_cnt_q  <= '0;
            ref_ack_q  <= 1'b0;
            zq_req_q   <= 1'b0;
            zq_cnt_q   <= '0;
            zq_ack_q   <= 1'b0;
        end else begin
            calib_q    <= calib_d;
            cal_cnt_q  <= cal_cnt_d;
            rd_vld_q   <= rd_vld_d;
            rd_idx_q   <= rd_idx_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            ref_req_q  <= ref_req_d;
            ref_cnt_q  <= ref_cnt_d;
            ref_ack_q  <= ref_ack_d;
            zq_req_q   <= zq_req_d;
            zq_cnt_q   <= zq_cnt_d;
            zq_ack_q   <= zq_ack_d;
        end
    end

    assign app_rd_data         = rd_data_q;
    assign app_rd_data_valid   = rd_valid_q;
    assign app_rd_data_end     = rd_valid_q;
    assign app_ref_ack         = ref_ack_q;
    assign app_zq_ack          = zq_ack_q;
    assign app_sr_active       = 1'b0;
    assign init_calib_complete = calib_q;

endmodule

// File: tb/tb_mig_app_bram_responder.sv
// Directed self-checking bench for mig_app_bram_responder: calibration, write
// ordering, masking, aliasing, read latency, reset flush and maintenance acks.
module tb_mig_app_bram_responder;
    import mig_app_pkg::*;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 256;
    localparam int MASK_W = DATA_W / 8;

    localparam logic [DATA_W-1:0] D0 = {2{32'hcafebabe, 32'h12345678, 32'hAA55AA55, 32'h55AA55AA}};
    localparam logic [DATA_W-1:0] D1 = {8{32'h0badf00d}};
    localparam logic [DATA_W-1:0] D2 = {4{64'h0123456789abcdef}};
    localparam logic [DATA_W-1:0] D3 = {8{32'h13572468}};
    localparam logic [DATA_W-1:0] DA = {8{32'haaaa0001}};
    localparam logic [DATA_W-1:0] DB = {8{32'hbbbb0002}};
    localparam logic [DATA_W-1:0] DC = {8{32'hcccc0003}};

    logic               clk = 1'b0;
    logic               rst;
    logic [ADDR_W-1:0]  app_addr;
    logic [2:0]         app_cmd;
    logic               app_en;
    logic               app_rdy;
    logic [DATA_W-1:0]  app_wdf_data;
    logic [MASK_W-1:0]  app_wdf_mask;
    logic               app_wdf_wren;
    logic               app_wdf_end;
    logic               app_wdf_rdy;
    logic [DATA_W-1:0]  app_rd_data;
    logic               app_rd_data_valid;
    logic               app_rd_data_end;
    logic               app_ref_req;
    logic               app_zq_req;
    logic               app_sr_req;
    logic               app_ref_ack;
    logic               app_zq_ack;
    logic               app_sr_active;
    logic               init_calib_complete;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mig_app_bram_responder dut (
        .clk                 (clk),
        .rst                 (rst),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .app_rd_data_end     (app_rd_data_end),
        .app_ref_req         (app_ref_req),
        .app_zq_req          (app_zq_req),
        .app_sr_req          (app_sr_req),
        .app_ref_ack         (app_ref_ack),
        .app_zq_ack          (app_zq_ack),
        .app_sr_active       (app_sr_active),
        .init_calib_complete (init_calib_complete)
    );

    // All driving happens 1 time unit after a rising edge, well clear of it.
    task automatic send_cmd(input logic [2:0] cmd, input logic [ADDR_W-1:0] addr, output bit ok);
        app_cmd = cmd; app_addr = addr; app_en = 1'b1; ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (app_rdy) begin @(posedge clk); ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        #1; app_en = 1'b0;
    endtask

    task automatic send_data(input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m, output bit ok);
        app_wdf_data = d; app_wdf_mask = m; app_wdf_wren = 1'b1; app_wdf_end = 1'b1; ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (app_wdf_rdy) begin @(posedge clk); ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        #1; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    endtask

    task automatic send_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] d,
                              input logic [MASK_W-1:0] m, output bit ok);
        app_cmd = CMD_WRITE; app_addr = addr; app_en = 1'b1;
        app_wdf_data = d; app_wdf_mask = m; app_wdf_wren = 1'b1; app_wdf_end = 1'b1; ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (app_rdy && app_wdf_rdy) begin @(posedge clk); ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        #1; app_en = 1'b0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] addr, output logic [DATA_W-1:0] d,
                           output int lat, output bit ok);
        send_cmd(CMD_READ, addr, ok);
        lat = 0; d = '0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (app_rd_data_valid && lat == 0) begin lat = k; d = app_rd_data; end
        end
    endtask

    task automatic test_reset();
        bit early;
        rst = 1'b1; app_en = 1'b0; app_cmd = 3'b111; app_addr = '0;
        app_wdf_data = '0; app_wdf_mask = '0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
        app_ref_req = 1'b0; app_zq_req = 1'b0; app_sr_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (app_rdy !== 1'b0) begin bad++; $display("[TB] FAIL rst_app_rdy: got %b want 0", app_rdy); end
        total++; if (app_wdf_rdy !== 1'b0) begin bad++; $display("[TB] FAIL rst_wdf_rdy: got %b want 0", app_wdf_rdy); end
        total++; if (app_rd_data_valid !== 1'b0 || app_rd_data_end !== 1'b0) begin
            bad++; $display("[TB] FAIL rst_rd_valid: got %b/%b want 0/0", app_rd_data_valid, app_rd_data_end); end
        total++; if (app_rd_data !== '0) begin bad++; $display("[TB] FAIL rst_rd_data: got %h want 0", app_rd_data); end
        total++; if ({app_ref_ack, app_zq_ack, app_sr_active} !== 3'b000) begin
            bad++; $display("[TB] FAIL rst_maint: got %b want 000", {app_ref_ack, app_zq_ack, app_sr_active}); end
        total++; if (init_calib_complete !== 1'b0) begin bad++; $display("[TB] FAIL rst_calib: got %b want 0", init_calib_complete); end
        rst = 1'b0;
        early = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); #1;
            if (k < 64 && (init_calib_complete || app_rdy || app_wdf_rdy)) early = 1'b1;
        end
        total++; if (early !== 1'b0) begin bad++; $display("[TB] FAIL calib_early: got %b want 0", early); end
        total++; if (init_calib_complete !== 1'b1) begin bad++; $display("[TB] FAIL calib_at_64: got %b want 1", init_calib_complete); end
        total++; if ({app_rdy, app_wdf_rdy} !== 2'b11) begin
            bad++; $display("[TB] FAIL rdy_after_calib: got %b want 11", {app_rdy, app_wdf_rdy}); end
    endtask

    task automatic test_write_read_same();
        bit ok, rok; logic [DATA_W-1:0] d; int lat;
        send_write(28'h0, D0, '0, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL wr_same_accept: got %b want 1", ok); end
        do_read(28'h0, d, lat, rok);
        total++; if (rok !== 1'b1) begin bad++; $display("[TB] FAIL rd_same_accept: got %b want 1", rok); end
        total++; if (lat != 4) begin bad++; $display("[TB] FAIL rd_same_latency: got %0d want 4", lat); end
        total++; if (d !== D0) begin bad++; $display("[TB] FAIL rd_same_data: got %h want %h", d, D0); end
    endtask

    task automatic test_data_first();
        bit ok, ok2, rok; logic [DATA_W-1:0] d; int lat; bit rdy_seen;
        send_data(D1, '0, ok);
        total++; if (app_wdf_rdy !== 1'b1) begin bad++; $display("[TB] FAIL wdq_one_entry_rdy: got %b want 1", app_wdf_rdy); end
        repeat (2) @(posedge clk);
        #1;
        send_cmd(CMD_WRITE, 28'h40, ok2);
        do_read(28'h40, d, lat, rok);
        total++; if ({ok, ok2, rok} !== 3'b111) begin bad++; $display("[TB] FAIL data_first_accepts: got %b want 111", {ok, ok2, rok}); end
        total++; if (d !== D1 || lat != 4) begin
            bad++; $display("[TB] FAIL data_first_read: got %h lat %0d want %h lat 4", d, lat, D1); end

        send_cmd(CMD_WRITE, 28'h80, ok);
        rdy_seen = app_rdy;
        for (int i = 1; i < 5; i++) begin
            @(posedge clk); #1;
            if (app_rdy) rdy_seen = 1'b1;
        end
        total++; if (rdy_seen !== 1'b0) begin bad++; $display("[TB] FAIL cmd_first_rdy_low: got %b want 0", rdy_seen); end
        send_data(D2, '0, ok2);
        total++; if (app_rdy !== 1'b1) begin bad++; $display("[TB] FAIL cmd_first_rdy_back: got %b want 1", app_rdy); end
        do_read(28'h80, d, lat, rok);
        total++; if (d !== D2 || lat != 4 || {ok, ok2, rok} !== 3'b111) begin
            bad++; $display("[TB] FAIL cmd_first_read: got %h lat %0d want %h lat 4", d, lat, D2); end
    endtask

    task automatic test_mask_alias();
        bit ok, rok; logic [DATA_W-1:0] d; int lat;
        send_write(28'h28, '0, '0, ok);
        send_write(28'h28, {DATA_W{1'b1}}, 32'hFFFFFFFE, ok);
        do_read(28'h28, d, lat, rok);
        total++; if (d !== 256'hFF || lat != 4) begin
            bad++; $display("[TB] FAIL mask_byte0: got %h lat %0d want ff lat 4", d, lat); end
        send_write(28'h200, D3, '0, ok);
        do_read(28'h0, d, lat, rok);
        total++; if (d !== D3 || lat != 4) begin
            bad++; $display("[TB] FAIL alias_line0: got %h lat %0d want %h", d, lat, D3); end
    endtask

    task automatic test_back_to_back();
        bit ok; logic [11:0] vpat; logic [DATA_W-1:0] got [3]; int n;
        logic [ADDR_W-1:0] addrs [3];
        addrs[0] = 28'h08; addrs[1] = 28'h10; addrs[2] = 28'h18;
        send_write(addrs[0], DA, '0, ok);
        send_write(addrs[1], DB, '0, ok);
        send_write(addrs[2], DC, '0, ok);
        total++; if (app_rdy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_rdy_before: got %b want 1", app_rdy); end
        vpat = '0; n = 0;
        got[0] = '0; got[1] = '0; got[2] = '0;
        for (int k = 0; k < 12; k++) begin
            app_en = (k < 3); app_cmd = CMD_READ; app_addr = addrs[(k < 3) ? k : 0];
            @(posedge clk); #1;
            vpat[k] = app_rd_data_valid;
            if (app_rd_data_valid && n < 3) begin got[n] = app_rd_data; n++; end
        end
        app_en = 1'b0;
        total++; if (vpat !== 12'h070) begin bad++; $display("[TB] FAIL b2b_valid_pattern: got %b want 000001110000", vpat); end
        total++; if (got[0] !== DA || got[1] !== DB || got[2] !== DC) begin
            bad++; $display("[TB] FAIL b2b_order: got %h,%h,%h", got[0][31:0], got[1][31:0], got[2][31:0]); end
    endtask

    task automatic test_reset_mid_burst();
        bit ok, early; logic [11:0] vpat; logic [DATA_W-1:0] d; int lat;
        logic [ADDR_W-1:0] addrs [3];
        addrs[0] = 28'h08; addrs[1] = 28'h10; addrs[2] = 28'h18;
        vpat = '0;
        for (int k = 0; k < 12; k++) begin
            app_en = (k < 2); app_cmd = CMD_READ; app_addr = addrs[(k < 3) ? k : 0];
            if (k == 2) rst = 1'b1;
            @(posedge clk); #1;
            vpat[k] = app_rd_data_valid;
        end
        total++; if (vpat !== 12'h000) begin bad++; $display("[TB] FAIL rstmid_no_valid: got %b want 0", vpat); end
        total++; if ({init_calib_complete, app_rdy} !== 2'b00) begin
            bad++; $display("[TB] FAIL rstmid_calib_cleared: got %b want 00", {init_calib_complete, app_rdy}); end
        rst = 1'b0;
        early = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); #1;
            if (k < 64 && (init_calib_complete || app_rdy)) early = 1'b1;
        end
        total++; if (early !== 1'b0 || init_calib_complete !== 1'b1) begin
            bad++; $display("[TB] FAIL rstmid_recalib: got early=%b calib=%b want 0/1", early, init_calib_complete); end
        do_read(28'h10, d, lat, ok);
        total++; if (d !== DB || lat != 4) begin bad++; $display("[TB] FAIL rstmid_retained: got %h lat %0d want %h", d, lat, DB); end
    endtask

    task automatic test_maint();
        int acks, first, other;
        acks = 0; first = 0; other = 0;
        app_ref_req = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk); #1;
            if (app_ref_ack) begin acks++; if (first == 0) first = i; end
            if (app_zq_ack) other++;
            app_ref_req = (i == 2);
        end
        total++; if (acks != 1) begin bad++; $display("[TB] FAIL ref_ack_count: got %0d want 1", acks); end
        total++; if (first != 5) begin bad++; $display("[TB] FAIL ref_ack_timing: got cycle %0d want 5", first); end
        acks = 0; first = 0;
        app_zq_req = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (app_zq_ack) begin acks++; if (first == 0) first = i; end
            if (app_ref_ack) other++;
            app_zq_req = 1'b0;
        end
        total++; if (acks != 1 || first != 5) begin
            bad++; $display("[TB] FAIL zq_ack: got count %0d cycle %0d want 1 at 5", acks, first); end
        total++; if (other != 0) begin bad++; $display("[TB] FAIL maint_cross_ack: got %0d want 0", other); end
    endtask

    initial begin
        test_reset();
        test_write_read_same();
        test_data_first();
        test_mask_alias();
        test_back_to_back();
        test_reset_mid_burst();
        test_maint();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
